// File: rtl/xaui_link_sequencer_if.sv
// Status/control bundle between the XAUI link sequencer and a GTX quad.
// The code_err_count signal exists only when XAUI_SEQ_STATS_EN is defined.
interface xaui_link_sequencer_if;
  logic [3:0] mgt_rxlock;
  logic [3:0] mgt_rxsyncok;
  logic [3:0] mgt_rxbufferr;
  logic [7:0] mgt_rxcodevalid;
  logic       mgt_tx_rst;
  logic       mgt_rx_rst;
  logic [3:0] mgt_rxencommaalign;
  logic       mgt_rxenchansync;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retry_count;
`ifdef XAUI_SEQ_STATS_EN
  logic [15:0] code_err_count;
`endif

  // Sequencer side: consumes lane status, drives quad controls and link status.
  modport master (
    input  mgt_rxlock, mgt_rxsyncok, mgt_rxbufferr, mgt_rxcodevalid,
    output mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync,
    output link_up, state, retry_count
`ifdef XAUI_SEQ_STATS_EN
    , output code_err_count
`endif
  );

  // Quad / observer side.
  modport slave (
    output mgt_rxlock, mgt_rxsyncok, mgt_rxbufferr, mgt_rxcodevalid,
    input  mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync,
    input  link_up, state, retry_count
`ifdef XAUI_SEQ_STATS_EN
    , input code_err_count
`endif
  );
endinterface

// File: rtl/xaui_link_sequencer.sv
// XAUI link bring-up sequencer: reset, lock, comma align, channel bond, monitor.
// Optional code-error statistics counter enabled by defining XAUI_SEQ_STATS_EN.
module xaui_link_sequencer #(
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned ALIGN_TIMEOUT   = 4096,
  parameter int unsigned CHANSYNC_CYCLES = 64
) (
  input  logic                   xaui_clk,
  input  logic                   mgt_reset,
  input  logic                   enable,
  xaui_link_sequencer_if.master  link
);

  localparam int unsigned DWELL_W = 16;
  localparam int unsigned RETRY_W = 8;
  localparam int unsigned LANES   = 4;
`ifdef XAUI_SEQ_STATS_EN
  localparam int unsigned CERR_W  = 16;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST       = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_CHANSYNC  = 3'd4,
    ST_LINK_UP   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 tx_rst_q, tx_rst_d;
  logic                 rx_rst_q, rx_rst_d;
  logic [LANES-1:0]     comma_q, comma_d;
  logic                 chansync_q, chansync_d;
  logic                 link_up_q, link_up_d;

  logic                 lock_all_c;
  logic                 sync_all_c;
  logic                 buf_err_c;
  logic                 code_ok_c;
  logic                 fail_c;

  assign lock_all_c = &link.mgt_rxlock;
  assign sync_all_c = &link.mgt_rxsyncok;
  assign buf_err_c  = |link.mgt_rxbufferr;
  assign code_ok_c  = &link.mgt_rxcodevalid;

  // Next state; success conditions are tested before timeouts so they win a tie.
  always_comb begin
    state_d = state_q;
    fail_c  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RST;
        end
        ST_RST: begin
          if (dwell_q == DWELL_W'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_all_c) begin
            state_d = ST_ALIGN;
          end else if (dwell_q == DWELL_W'(LOCK_TIMEOUT - 1)) begin
            state_d = ST_RST;
            fail_c  = 1'b1;
          end
        end
        ST_ALIGN: begin
          if (sync_all_c) begin
            state_d = ST_CHANSYNC;
          end else if (dwell_q == DWELL_W'(ALIGN_TIMEOUT - 1)) begin
            state_d = ST_RST;
            fail_c  = 1'b1;
          end
        end
        ST_CHANSYNC: begin
          if (dwell_q == DWELL_W'(CHANSYNC_CYCLES - 1)) begin
            if (code_ok_c) begin
              state_d = ST_LINK_UP;
            end else begin
              state_d = ST_RST;
              fail_c  = 1'b1;
            end
          end
        end
        ST_LINK_UP: begin
          if (!lock_all_c || !sync_all_c || buf_err_c) begin
            state_d = ST_RST;
            fail_c  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Dwell counter restarts on every state entry.
  always_comb begin
    dwell_d = dwell_q + DWELL_W'(1);
    if (state_d != state_q) begin
      dwell_d = '0;
    end
  end

  always_comb begin
    retry_d = retry_q;
    if (fail_c && (retry_q != {RETRY_W{1'b1}})) begin
      retry_d = retry_q + RETRY_W'(1);
    end
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    tx_rst_d   = 1'b0;
    rx_rst_d   = 1'b0;
    comma_d    = '0;
    chansync_d = 1'b0;
    link_up_d  = 1'b0;
    unique case (state_d)
      ST_IDLE, ST_RST: begin
        tx_rst_d = 1'b1;
        rx_rst_d = 1'b1;
      end
      ST_WAIT_LOCK: begin
      end
      ST_ALIGN: begin
        comma_d = {LANES{1'b1}};
      end
      ST_CHANSYNC: begin
        comma_d    = {LANES{1'b1}};
        chansync_d = 1'b1;
      end
      ST_LINK_UP: begin
        chansync_d = 1'b1;
        link_up_d  = 1'b1;
      end
      default: begin
        tx_rst_d = 1'b1;
        rx_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge xaui_clk) begin
    if (mgt_reset) begin
      state_q    <= ST_IDLE;
      dwell_q    <= '0;
      retry_q    <= '0;
      tx_rst_q   <= 1'b1;
      rx_rst_q   <= 1'b1;
      comma_q    <= '0;
      chansync_q <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      retry_q    <= retry_d;
      tx_rst_q   <= tx_rst_d;
      rx_rst_q   <= rx_rst_d;
      comma_q    <= comma_d;
      chansync_q <= chansync_d;
      link_up_q  <= link_up_d;
    end
  end

`ifdef XAUI_SEQ_STATS_EN
  logic [CERR_W-1:0] cerr_q, cerr_d;

  // Counts LINK_UP cycles with any invalid code byte; only mgt_reset clears it.
  always_comb begin
    cerr_d = cerr_q;
    if ((state_q == ST_LINK_UP) && !code_ok_c && (cerr_q != {CERR_W{1'b1}})) begin
      cerr_d = cerr_q + CERR_W'(1);
    end
  end

  always_ff @(posedge xaui_clk) begin
    if (mgt_reset) begin
      cerr_q <= '0;
    end else begin
      cerr_q <= cerr_d;
    end
  end

  assign link.code_err_count = cerr_q;
`endif

  assign link.mgt_tx_rst         = tx_rst_q;
  assign link.mgt_rx_rst         = rx_rst_q;
  assign link.mgt_rxencommaalign = comma_q;
  assign link.mgt_rxenchansync   = chansync_q;
  assign link.link_up            = link_up_q;
  assign link.state              = 3'(state_q);
  assign link.retry_count        = retry_q;

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// Bench for xaui_link_sequencer: cycle model plus directed bring-up/failure scenarios.
module tb_xaui_link_sequencer;

  localparam int RST_CYCLES      = 16;
  localparam int LOCK_TIMEOUT    = 4096;
  localparam int ALIGN_TIMEOUT   = 4096;
  localparam int CHANSYNC_CYCLES = 64;

  logic clk = 1'b0;
  logic mgt_reset;
  logic enable;

  int n_vec = 0;
  int n_err = 0;

  xaui_link_sequencer_if u_if ();

  xaui_link_sequencer #(
    .RST_CYCLES      (RST_CYCLES),
    .LOCK_TIMEOUT    (LOCK_TIMEOUT),
    .ALIGN_TIMEOUT   (ALIGN_TIMEOUT),
    .CHANSYNC_CYCLES (CHANSYNC_CYCLES)
  ) dut (
    .xaui_clk  (clk),
    .mgt_reset (mgt_reset),
    .enable    (enable),
    .link      (u_if)
  );

  always #5 clk = ~clk;

  // Model: tracks which phase of bring-up we are in and how long we have been there.
  int m_state   = 0;
  int m_retry   = 0;
  int m_cerr    = 0;
  int m_entered = 0;
  int m_cycle   = 0;
  bit m_valid   = 1'b0;

  always @(posedge clk) begin
    int spent;
    int nxt;
    bit fl;
    spent = m_cycle + 1 - m_entered;
    nxt   = m_state;
    fl    = 1'b0;
    m_cycle <= m_cycle + 1;
    if (mgt_reset) begin
      m_state   <= 0;
      m_retry   <= 0;
      m_cerr    <= 0;
      m_entered <= m_cycle + 1;
      m_valid   <= 1'b1;
    end else if (m_valid) begin
      if (!enable) nxt = 0;
      else if (m_state == 0) nxt = 1;
      else if (m_state == 1) begin
        if (spent == RST_CYCLES) nxt = 2;
      end else if (m_state == 2) begin
        if (u_if.mgt_rxlock == 4'hF) nxt = 3;
        else if (spent == LOCK_TIMEOUT) begin nxt = 1; fl = 1'b1; end
      end else if (m_state == 3) begin
        if (u_if.mgt_rxsyncok == 4'hF) nxt = 4;
        else if (spent == ALIGN_TIMEOUT) begin nxt = 1; fl = 1'b1; end
      end else if (m_state == 4) begin
        if (spent == CHANSYNC_CYCLES) begin
          if (u_if.mgt_rxcodevalid == 8'hFF) nxt = 5;
          else begin nxt = 1; fl = 1'b1; end
        end
      end else begin
        if (u_if.mgt_rxlock != 4'hF || u_if.mgt_rxsyncok != 4'hF || u_if.mgt_rxbufferr != 4'h0) begin
          nxt = 1; fl = 1'b1;
        end
      end
      if (m_state == 5 && u_if.mgt_rxcodevalid != 8'hFF && m_cerr < 65535) m_cerr <= m_cerr + 1;
      if (fl && m_retry < 255) m_retry <= m_retry + 1;
      if (nxt != m_state) begin
        m_state   <= nxt;
        m_entered <= m_cycle + 1;
      end
    end
  end

  // Per-state {tx_rst, rx_rst, commaalign[3:0], enchansync, link_up}.
  function automatic logic [7:0] exp_outs(input int s);
    case (s)
      0, 1:    return 8'b1_1_0000_0_0;
      2:       return 8'b0_0_0000_0_0;
      3:       return 8'b0_0_1111_0_0;
      4:       return 8'b0_0_1111_1_0;
      default: return 8'b0_0_0000_1_1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Advance one cycle and compare all outputs against the model.
  task automatic tick();
    logic [7:0] act_o;
    @(posedge clk);
    #1;
    if (m_valid) begin
      act_o = {u_if.mgt_tx_rst, u_if.mgt_rx_rst, u_if.mgt_rxencommaalign,
               u_if.mgt_rxenchansync, u_if.link_up};
      n_vec++;
      if (int'(u_if.state) != m_state || act_o != exp_outs(m_state) ||
          int'(u_if.retry_count) != m_retry
`ifdef XAUI_SEQ_STATS_EN
          || int'(u_if.code_err_count) != m_cerr
`endif
         ) begin
        n_err++;
        $display("FAIL model @%0t: state %0d/%0d outs %b/%b retry %0d/%0d (got/expected)",
                 $time, u_if.state, m_state, act_o, exp_outs(m_state), u_if.retry_count, m_retry);
      end
    end
  endtask

  task automatic measure(input int s, input int len, input string nm);
    int n = 0;
    chk({nm, "_entry"}, int'(u_if.state), s);
    while (int'(u_if.state) == s && n < len + 8) begin
      n++;
      tick();
    end
    chk({nm, "_len"}, n, len);
  endtask

  task automatic bring_up(input string nm);
    measure(1, RST_CYCLES, {nm, "_rst"});
    measure(2, 1, {nm, "_lock"});
    measure(3, 1, {nm, "_align"});
    measure(4, CHANSYNC_CYCLES, {nm, "_chsync"});
    chk({nm, "_up_state"}, int'(u_if.state), 5);
    chk({nm, "_up_link"}, int'(u_if.link_up), 1);
  endtask

  initial begin
    mgt_reset              = 1'b1;
    enable                 = 1'b1;
    u_if.mgt_rxlock        = 4'hF;
    u_if.mgt_rxsyncok      = 4'hF;
    u_if.mgt_rxbufferr     = 4'h0;
    u_if.mgt_rxcodevalid   = 8'hFF;
    repeat (3) tick();
    mgt_reset = 1'b0;
    chk("reset_state", int'(u_if.state), 0);
    chk("reset_txrst", int'(u_if.mgt_tx_rst), 1);
    chk("reset_rxrst", int'(u_if.mgt_rx_rst), 1);
    chk("reset_retry", int'(u_if.retry_count), 0);
    tick();

    // Clean bring-up with all status good.
    bring_up("boot");
    chk("boot_retry", int'(u_if.retry_count), 0);
    repeat (5) tick();

    // One-cycle buffer error drops the link.
    u_if.mgt_rxbufferr = 4'h2;
    tick();
    u_if.mgt_rxbufferr = 4'h0;
    chk("buferr_state", int'(u_if.state), 1);
    chk("buferr_link", int'(u_if.link_up), 0);
    chk("buferr_txrst", int'(u_if.mgt_tx_rst), 1);
    chk("buferr_retry", int'(u_if.retry_count), 1);
    bring_up("relink1");

    // Sync loss, then stall in ALIGN and drop enable there.
    u_if.mgt_rxsyncok = 4'h0;
    tick();
    chk("syncloss_retry", int'(u_if.retry_count), 2);
    measure(1, RST_CYCLES, "sl_rst");
    measure(2, 1, "sl_lock");
    repeat (3) tick();
    chk("align_comma", int'(u_if.mgt_rxencommaalign), 15);
    enable = 1'b0;
    tick();
    chk("disable_state", int'(u_if.state), 0);
    chk("disable_comma", int'(u_if.mgt_rxencommaalign), 0);
    chk("disable_retry", int'(u_if.retry_count), 2);
    enable = 1'b1;
    u_if.mgt_rxsyncok = 4'hF;
    tick();
    bring_up("reenable");
    chk("reenable_retry", int'(u_if.retry_count), 2);

    // Lock loss, then full WAIT_LOCK timeout.
    u_if.mgt_rxlock = 4'h7;
    tick();
    chk("lockloss_retry", int'(u_if.retry_count), 3);
    measure(1, RST_CYCLES, "to_rst");
    measure(2, LOCK_TIMEOUT, "lock_timeout");
    chk("timeout_retry", int'(u_if.retry_count), 4);

    // Lock arrives on the timeout cycle itself: success wins.
    measure(1, RST_CYCLES, "tie_rst");
    repeat (LOCK_TIMEOUT - 1) tick();
    chk("tie_pre_state", int'(u_if.state), 2);
    u_if.mgt_rxlock = 4'hF;
    tick();
    chk("tie_state", int'(u_if.state), 3);
    chk("tie_retry", int'(u_if.retry_count), 4);
    measure(3, 1, "tie_align");
    measure(4, CHANSYNC_CYCLES, "tie_chsync");
    chk("tie_up", int'(u_if.state), 5);

    // Bad code bytes while up: counted (when built in) but link holds.
    u_if.mgt_rxcodevalid = 8'hFE;
    repeat (10) tick();
    chk("cerr_state", int'(u_if.state), 5);
`ifdef XAUI_SEQ_STATS_EN
    chk("cerr_count", int'(u_if.code_err_count), 10);
`endif

    // Lock blip with bad codes held: CHANSYNC check fails every round.
    u_if.mgt_rxlock = 4'h0;
    tick();
    u_if.mgt_rxlock = 4'hF;
    chk("blip_retry", int'(u_if.retry_count), 5);
    measure(1, RST_CYCLES, "cf_rst");
    measure(2, 1, "cf_lock");
    measure(3, 1, "cf_align");
    measure(4, CHANSYNC_CYCLES, "cf_chsync");
    chk("cf_state", int'(u_if.state), 1);
    chk("cf_retry", int'(u_if.retry_count), 6);
    for (int i = 0; i < 30000; i++) begin
      if (u_if.retry_count == 8'd255) break;
      tick();
    end
    chk("sat_reach", int'(u_if.retry_count), 255);
    repeat (250) tick();
    chk("sat_hold", int'(u_if.retry_count), 255);

    // Reset in the middle of a sequence abandons it and clears retries.
    for (int i = 0; i < 200; i++) begin
      if (u_if.state == 3'd4) break;
      tick();
    end
    chk("pre_reset_state", int'(u_if.state), 4);
    mgt_reset = 1'b1;
    tick();
    chk("midreset_state", int'(u_if.state), 0);
    chk("midreset_retry", int'(u_if.retry_count), 0);
    chk("midreset_chsync", int'(u_if.mgt_rxenchansync), 0);
`ifdef XAUI_SEQ_STATS_EN
    chk("midreset_cerr", int'(u_if.code_err_count), 0);
`endif
    mgt_reset = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    chk("park_state", int'(u_if.state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xaui_link_sequencer.md
XAUI_LINK_SEQUENCER -- requirements
Module: xaui_link_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles mgt_tx_rst/mgt_rx_rst are held high in RST.
REQ-002 Parameter LOCK_TIMEOUT, default 4096: maximum cycles allowed in WAIT_LOCK.
REQ-003 Parameter ALIGN_TIMEOUT, default 4096: maximum cycles allowed in ALIGN.
REQ-004 Parameter CHANSYNC_CYCLES, default 64: fixed dwell in CHANSYNC before the code-valid check.
REQ-005 xaui_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 mgt_reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  high = bring link up and hold it; low = park in IDLE.
REQ-008 mgt_rxlock, mgt_rxsyncok, mgt_rxbufferr  in  4 each  per-lane status from the GTX quad.
REQ-009 mgt_rxcodevalid  in  8  per-byte 8b10b code valid, 2 bits per lane.
REQ-010 mgt_tx_rst, mgt_rx_rst  out  1 each  quad TX/RX reset.
REQ-011 mgt_rxencommaalign  out  4  per-lane comma-align enable.
REQ-012 mgt_rxenchansync  out  1  channel-bonding enable.
REQ-013 link_up  out  1  high only in LINK_UP.
REQ-014 state  out  3  encoding IDLE=0, RST=1, WAIT_LOCK=2, ALIGN=3, CHANSYNC=4, LINK_UP=5.
REQ-015 retry_count  out  8  saturating count of failure-driven returns to RST.

Function
REQ-016 All outputs SHALL be registered; outputs reflect a state transition one cycle after the triggering input is sampled.
REQ-017 Per-state outputs (tx_rst, rx_rst, encommaalign, enchansync, link_up): IDLE 1,1,0,0,0; RST 1,1,0,0,0; WAIT_LOCK 0,0,0,0,0; ALIGN 0,0,4'hF,0,0; CHANSYNC 0,0,4'hF,1,0; LINK_UP 0,0,4'h0,1,1.
REQ-018 IDLE -> RST when enable=1.
REQ-019 RST -> WAIT_LOCK after exactly RST_CYCLES cycles in RST.
REQ-020 WAIT_LOCK -> ALIGN when mgt_rxlock==4'hF; else -> RST on LOCK_TIMEOUT cycles elapsed.
REQ-021 ALIGN -> CHANSYNC when mgt_rxsyncok==4'hF; else -> RST on ALIGN_TIMEOUT cycles elapsed.
REQ-022 CHANSYNC: after CHANSYNC_CYCLES cycles, -> LINK_UP if mgt_rxcodevalid==8'hFF, else -> RST.
REQ-023 LINK_UP -> RST when any mgt_rxlock bit low, any mgt_rxsyncok bit low, or any mgt_rxbufferr bit high.
REQ-024 One 16-bit dwell counter SHALL clear on every state entry and increment each cycle in-state; it is not free-running.
REQ-025 Each failure transition (timeout, CHANSYNC check fail, LINK_UP loss) SHALL increment retry_count, saturating at 255; IDLE->RST and RST->WAIT_LOCK do not increment.
REQ-026 enable=0 SHALL force IDLE from any state on the next cycle, overriding all other conditions; retry_count is not cleared.
REQ-027 Success condition and timeout in the same cycle: success wins, no retry increment.

Reset
REQ-028 mgt_reset=1 SHALL, on the next edge, set state=IDLE, clear dwell counter and retry_count, and drive IDLE outputs, regardless of current state.
REQ-029 Reset mid-sequence SHALL abandon the sequence; no partial retry increment.

Configuration
REQ-030 Macro XAUI_SEQ_STATS_EN defined: add output code_err_count (16 bits), incremented once per cycle in LINK_UP in which mgt_rxcodevalid!=8'hFF, saturating at 65535, cleared by mgt_reset only.
REQ-031 Macro XAUI_SEQ_STATS_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset, enable=1, all status inputs good from cycle 0 -> state 1 for 16 cycles, 2, 3, 4 for 64 cycles, then 5 with link_up=1, retry_count=0.
REQ-033 enable=1, mgt_rxlock=4'h7 held -> WAIT_LOCK exits to RST after 4096 cycles, retry_count=1; repeats reach 255 and stay there.
REQ-034 In LINK_UP, mgt_rxbufferr=4'h2 for one cycle -> next cycle state=1, link_up=0, tx/rx_rst=1, retry_count +1.
REQ-035 In ALIGN, drop enable -> next cycle state=0, mgt_rxencommaalign=0; re-raise -> sequence restarts from RST with retry_count unchanged.
REQ-036 In WAIT_LOCK, mgt_rxlock becomes 4'hF on cycle 4096 (timeout cycle) -> state=3, retry_count unchanged.
REQ-037 With XAUI_SEQ_STATS_EN, in LINK_UP, mgt_rxcodevalid=8'hFE for 10 cycles -> code_err_count=10, link remains up.
